// File: rtl/expiry_alarm_controller.sv
// End-of-countdown alert sequencer: blinks the display and beeps for a fixed number of cycles
// once a live run reaches zero, then holds a silent expired state until a key acknowledges it.
module expiry_alarm_controller #(
    parameter int unsigned BLINK_HALF = 50000,
    parameter int unsigned BEEP_COUNT = 5,
    parameter int unsigned VAL_W      = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             running,
    input  logic [VAL_W-1:0] remaining,
    input  logic             keydown_clear,
    input  logic             keydown_start,
    output logic             display_en,
    output logic             buzzer,
    output logic             alarm_active,
    output logic             expired
);

    localparam int unsigned PH_W = $clog2(BLINK_HALF + 1);
    localparam int unsigned BP_W = $clog2(BEEP_COUNT + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(BLINK_HALF - 1);
    localparam logic [BP_W-1:0] BP_DONE = BP_W'(BEEP_COUNT);

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StAlarmOn,
        StAlarmOff,
        StSilent
    } state_e;

    state_e          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [BP_W-1:0] beep_q, beep_d, beep_inc;
    logic            ack, phase_last;
    logic            display_en_d, buzzer_d, alarm_active_d, expired_d;

    assign ack        = keydown_clear | keydown_start;
    assign phase_last = (phase_q == PH_LAST);
    assign beep_inc   = beep_q + BP_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            phase_q <= '0;
            beep_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            beep_q  <= beep_d;
        end
    end

    // Counters default to zero so they rest at 0 outside the blink states.
    always_comb begin
        state_d = state_q;
        phase_d = '0;
        beep_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (running && remaining != '0) state_d = StArmed;
            end
            StArmed: begin
                // Zero wins over running=0: the countdown may drop running as it hits zero.
                if (remaining == '0) state_d = StAlarmOn;
                else if (!running)   state_d = StIdle;
            end
            StAlarmOn: begin
                beep_d = beep_q;
                if (ack) begin
                    state_d = StIdle;
                    beep_d  = '0;
                end else if (phase_last) begin
                    state_d = StAlarmOff;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            StAlarmOff: begin
                beep_d = beep_q;
                if (ack) begin
                    state_d = StIdle;
                    beep_d  = '0;
                end else if (phase_last) begin
                    if (beep_inc == BP_DONE) begin
                        state_d = StSilent;
                        beep_d  = '0;
                    end else begin
                        state_d = StAlarmOn;
                        beep_d  = beep_inc;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            StSilent: begin
                if (ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        display_en_d   = (state_d != StAlarmOff);
        buzzer_d       = (state_d == StAlarmOn);
        alarm_active_d = (state_d == StAlarmOn) || (state_d == StAlarmOff);
        expired_d      = (state_q == StArmed) && (state_d == StAlarmOn);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            display_en   <= 1'b1;
            buzzer       <= 1'b0;
            alarm_active <= 1'b0;
            expired      <= 1'b0;
        end else begin
            display_en   <= display_en_d;
            buzzer       <= buzzer_d;
            alarm_active <= alarm_active_d;
            expired      <= expired_d;
        end
    end

endmodule

// File: tb/tb_expiry_alarm_controller.sv
// Scoreboard bench for expiry_alarm_controller with BLINK_HALF=4, BEEP_COUNT=2.
module tb_expiry_alarm_controller;

    localparam int unsigned VAL_W = 7;

    // Output vector order: {display_en, buzzer, alarm_active, expired}
    localparam logic [3:0] O_IDLE  = 4'b1000;
    localparam logic [3:0] O_FIRST = 4'b1111;
    localparam logic [3:0] O_ON    = 4'b1110;
    localparam logic [3:0] O_OFF   = 4'b0010;

    typedef struct {
        logic [3:0] o;
        string      name;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             running = 1'b0;
    logic [VAL_W-1:0] remaining = '0;
    logic             keydown_clear = 1'b0;
    logic             keydown_start = 1'b0;
    logic             display_en, buzzer, alarm_active, expired;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    expiry_alarm_controller #(
        .BLINK_HALF(4),
        .BEEP_COUNT(2),
        .VAL_W     (VAL_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .running      (running),
        .remaining    (remaining),
        .keydown_clear(keydown_clear),
        .keydown_start(keydown_start),
        .display_en   (display_en),
        .buzzer       (buzzer),
        .alarm_active (alarm_active),
        .expired      (expired)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the coming edge.
    task automatic cyc(input logic r, input logic run, input logic [VAL_W-1:0] rem,
                       input logic clr, input logic st, input logic [3:0] e, input string nm);
        exp_t x;
        @(negedge clk);
        rst           = r;
        running       = run;
        remaining     = rem;
        keydown_clear = clr;
        keydown_start = st;
        x.o           = e;
        x.name        = nm;
        q.push_back(x);
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        exp_t       x;
        logic [3:0] got;
        #1;
        if (q.size() > 0) begin
            x   = q.pop_front();
            got = {display_en, buzzer, alarm_active, expired};
            checks++;
            if (got !== x.o) begin
                errors++;
                $display("FAIL %s: got {en,buz,act,exp}=%b expected %b", x.name, got, x.o);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: stimulus did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and idle
        cyc(1, 0, 0, 0, 0, O_IDLE, "reset0");
        cyc(1, 0, 0, 0, 0, O_IDLE, "reset1");
        cyc(0, 0, 0, 0, 0, O_IDLE, "idle");

        // Full alarm run: 4 on, 4 off, 4 on, 4 off, then silent
        cyc(0, 1, 3, 0, 0, O_IDLE, "arm");
        cyc(0, 1, 2, 0, 0, O_IDLE, "armed_2");
        cyc(0, 1, 1, 0, 0, O_IDLE, "armed_1");
        cyc(0, 1, 0, 0, 0, O_FIRST, "expire");
        for (int i = 1; i < 16; i++)
            cyc(0, 0, 0, 0, 0, ((i % 8) < 4) ? O_ON : O_OFF, $sformatf("blink_%0d", i));
        cyc(0, 0, 0, 0, 0, O_IDLE, "silent_entry");

        // Silent ignores countdown activity that would re-alarm from idle
        for (int i = 0; i < 20; i++)
            cyc(0, (i % 4) != 3, ((i % 3) == 2) ? 7'd0 : 7'(i * 3 + 1), 0, 0, O_IDLE,
                $sformatf("silent_hold_%0d", i));
        cyc(0, 0, 0, 1, 0, O_IDLE, "ack_clear");

        // Re-arm, then acknowledge with start in the 2nd on-cycle
        cyc(0, 1, 5, 0, 0, O_IDLE, "rearm");
        cyc(0, 1, 4, 0, 0, O_IDLE, "rearm_4");
        cyc(0, 1, 0, 0, 0, O_FIRST, "rearm_expire");
        cyc(0, 0, 0, 0, 1, O_IDLE, "ack_start_2nd");
        cyc(0, 0, 0, 0, 0, O_IDLE, "after_ack_idle");

        // Acknowledge coinciding with the on-phase terminal count
        cyc(0, 1, 5, 0, 0, O_IDLE, "arm_tc");
        cyc(0, 1, 0, 0, 0, O_FIRST, "expire_tc");
        cyc(0, 0, 0, 0, 0, O_ON, "on_p1");
        cyc(0, 0, 0, 0, 0, O_ON, "on_p2");
        cyc(0, 0, 0, 0, 0, O_ON, "on_p3");
        cyc(0, 0, 0, 0, 1, O_IDLE, "ack_at_tc");
        cyc(0, 0, 0, 0, 0, O_IDLE, "ack_at_tc_hold");

        // Zero-length run never alarms
        cyc(0, 1, 0, 0, 0, O_IDLE, "zero_run_0");
        cyc(0, 1, 0, 0, 0, O_IDLE, "zero_run_1");
        cyc(0, 0, 0, 0, 0, O_IDLE, "zero_run_2");

        // Early stop from armed returns to idle
        cyc(0, 1, 7, 0, 0, O_IDLE, "arm_stop");
        cyc(0, 0, 7, 0, 0, O_IDLE, "stop_early");
        cyc(0, 0, 0, 0, 0, O_IDLE, "stopped_no_alarm");

        // Zero and running drop on the same edge still alarms
        cyc(0, 1, 2, 0, 0, O_IDLE, "arm_simul");
        cyc(0, 0, 0, 0, 0, O_FIRST, "simul_expire");
        cyc(0, 0, 0, 0, 0, O_ON, "simul_on1");
        cyc(0, 0, 0, 0, 0, O_ON, "simul_on2");
        cyc(0, 0, 0, 0, 0, O_ON, "simul_on3");
        cyc(0, 0, 0, 0, 0, O_OFF, "simul_off0");

        // Reset during the off phase
        cyc(1, 0, 0, 0, 0, O_IDLE, "reset_in_off");
        cyc(0, 0, 0, 0, 0, O_IDLE, "post_reset");

        // Post-reset alarm starts from a fresh beep count
        cyc(0, 1, 1, 0, 0, O_IDLE, "arm_fresh");
        cyc(0, 1, 0, 0, 0, O_FIRST, "fresh_expire");
        for (int i = 1; i < 16; i++)
            cyc(0, 0, 0, 0, 0, ((i % 8) < 4) ? O_ON : O_OFF, $sformatf("fresh_blink_%0d", i));
        cyc(0, 0, 0, 0, 0, O_IDLE, "fresh_silent");

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
